// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard controller: the stage-tag layout, the bubble tag,
// and the hazard-bus bit positions that decode also uses.
package hazard_control_unit_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Shadow tag that follows each instruction through EX, MEM and WB.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } stage_tag_t;

  localparam int TAG_W = $bits(stage_tag_t);

  localparam stage_tag_t BUBBLE_TAG = '{valid: 1'b0, rd: REG_X0, we: 1'b0, load: 1'b0};

  // Bit positions inside RAW_hazards = {rs1_ex, rs2_ex, rs1_mem, rs2_mem}.
  localparam int RAW_RS1_EX  = 3;
  localparam int RAW_RS2_EX  = 2;
  localparam int RAW_RS1_MEM = 1;
  localparam int RAW_RS2_MEM = 0;

  // Bit positions inside RAW_mem_wb_hazards = {load_raw_wb_dec_rs1, load_raw_wb_dec_rs2}.
  localparam int RAW_WB_RS1 = 1;
  localparam int RAW_WB_RS2 = 0;

  localparam int STAGE_EX   = 0;
  localparam int STAGE_MEM  = 1;
  localparam int STAGE_WB   = 2;
  localparam int NUM_STAGES = 3;

  localparam int OP_RS1 = 0;
  localparam int OP_RS2 = 1;

  // A tag produces register r only when it is a live, writing instruction and r is not x0.
  function automatic logic tag_writes(input stage_tag_t tag, input logic [4:0] r);
    return tag.valid && tag.we && (tag.rd == r) && (r != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_control_unit_stage_tag_match.sv
// Compares one shadow stage tag against one decode source operand.
module stage_tag_match
  import hazard_control_unit_pkg::*;
(
  input  logic [TAG_W-1:0] tag,
  input  logic [4:0]       rs,
  input  logic             use_rs,
  input  logic             dec_valid,
  output logic             match,
  output logic             is_load
);

  stage_tag_t tag_s;

  assign tag_s   = stage_tag_t'(tag);
  assign match   = dec_valid & use_rs & tag_writes(tag_s, rs);
  assign is_load = tag_s.load;

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller: shadow EX/MEM/WB destination tags, RAW forwarding bits,
// load-use stall, redirect flush, WB write qualifier and saturating event counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_rf_wb,
  input  logic             dec_mem_load,
  input  logic             redirect,
  output logic [3:0]       RAW_hazards,
  output logic [1:0]       RAW_mem_wb_hazards,
  output logic             we_valid,
  output logic             stall,
  output logic             flush_if,
  output logic             flush_dec,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stage_tag_t ex_tag;
  stage_tag_t mem_tag;
  stage_tag_t wb_tag;
  stage_tag_t ex_next;
  stage_tag_t tags [NUM_STAGES];

  logic [4:0] rs_vec  [2];
  logic       use_vec [2];
  logic       match   [NUM_STAGES][2];
  logic       is_load [NUM_STAGES][2];

  logic load_use_ex;
  logic load_use_mem;

  assign tags[STAGE_EX]  = ex_tag;
  assign tags[STAGE_MEM] = mem_tag;
  assign tags[STAGE_WB]  = wb_tag;

  assign rs_vec[OP_RS1]  = dec_rs1;
  assign rs_vec[OP_RS2]  = dec_rs2;
  assign use_vec[OP_RS1] = dec_use_rs1;
  assign use_vec[OP_RS2] = dec_use_rs2;

  // One comparator per (stage, operand) pair.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    for (genvar n = 0; n < 2; n++) begin : g_op
      stage_tag_match u_match (
        .tag       (tags[s]),
        .rs        (rs_vec[n]),
        .use_rs    (use_vec[n]),
        .dec_valid (dec_valid),
        .match     (match[s][n]),
        .is_load   (is_load[s][n])
      );
    end
  end

  assign load_use_ex  = (match[STAGE_EX][OP_RS1]  | match[STAGE_EX][OP_RS2])  & ex_tag.load;
  assign load_use_mem = (match[STAGE_MEM][OP_RS1] | match[STAGE_MEM][OP_RS2]) & mem_tag.load;

  // Redirect wins: the consumer is being squashed anyway, so there is nothing to wait for.
  assign stall     = ~redirect & (load_use_ex | load_use_mem);
  assign flush_if  = redirect;
  assign flush_dec = redirect;
  assign we_valid  = wb_tag.valid & wb_tag.we;

  always_comb begin
    RAW_hazards              = '0;
    RAW_hazards[RAW_RS1_EX]  = match[STAGE_EX][OP_RS1]  & ~is_load[STAGE_EX][OP_RS1];
    RAW_hazards[RAW_RS2_EX]  = match[STAGE_EX][OP_RS2]  & ~is_load[STAGE_EX][OP_RS2];
    RAW_hazards[RAW_RS1_MEM] = match[STAGE_MEM][OP_RS1] & ~is_load[STAGE_MEM][OP_RS1];
    RAW_hazards[RAW_RS2_MEM] = match[STAGE_MEM][OP_RS2] & ~is_load[STAGE_MEM][OP_RS2];
  end

  // A load in WB must be picked up from the regfile/WB bypass, not the MEM forward path.
  always_comb begin
    RAW_mem_wb_hazards             = '0;
    RAW_mem_wb_hazards[RAW_WB_RS1] = match[STAGE_WB][OP_RS1] & is_load[STAGE_WB][OP_RS1];
    RAW_mem_wb_hazards[RAW_WB_RS2] = match[STAGE_WB][OP_RS2] & is_load[STAGE_WB][OP_RS2];
  end

  always_comb begin
    ex_next = BUBBLE_TAG;
    if (dec_valid && !stall && !redirect) begin
      ex_next.valid = 1'b1;
      ex_next.rd    = dec_rd;
      ex_next.we    = dec_rf_wb;
      ex_next.load  = dec_mem_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag  <= BUBBLE_TAG;
      mem_tag <= BUBBLE_TAG;
      wb_tag  <= BUBBLE_TAG;
    end else begin
      ex_tag  <= ex_next;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (redirect && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage core; it sequences the decode stage's forwarding muxes and the IF/DEC pipeline registers. It keeps its own shadow pipeline of destination-register tags for EX, MEM and WB, and compares them against the operands of the instruction in decode. From that comparison it produces the `RAW_hazards` and `RAW_mem_wb_hazards` buses, load-use stalls, redirect flushes, the WB write qualifier `we_valid`, and stall/flush performance counters.

## Interface
- `CNT_W`, 32, width of the stall and flush performance counters
- `clk  in  1` system clock, rising edge
- `rst  in  1` asynchronous, active-high reset
- `dec_valid  in  1` decode holds a real instruction
- `dec_rs1`, `dec_rs2  in  5` source addresses (LUI already presents rs1 = 0)
- `dec_use_rs1`, `dec_use_rs2  in  1` the decoded opcode reads that operand
- `dec_rd  in  5` destination address of the decode instruction
- `dec_rf_wb  in  1` the decode instruction writes the regfile
- `dec_mem_load  in  1` the decode instruction is a load
- `redirect  in  1` taken branch or jump resolved in EX this cycle
- `RAW_hazards  out  4` {rs1_ex, rs2_ex, rs1_mem, rs2_mem}
- `RAW_mem_wb_hazards  out  2` {load_raw_wb_dec_rs1, load_raw_wb_dec_rs2}
- `we_valid  out  1` the WB-stage write is architecturally valid
- `stall  out  1` hold the PC, IF/DEC register and decode; insert a bubble into EX
- `flush_if`, `flush_dec  out  1` squash the IF/DEC instruction; bubble into EX
- `stall_cnt`, `flush_cnt  out  CNT_W` saturating event counters

## Operation
- Shadow tag per stage EX/MEM/WB = {valid, rd, we, load}. A tag "writes r" only when valid & we & rd == r & r != 0.
- Advance on every clock edge; EX/MEM/WB never stall:
  - EX ← bubble if `stall` | `redirect` | !`dec_valid`; otherwise {1, dec_rd, dec_rf_wb, dec_mem_load}.
  - MEM ← EX; WB ← MEM.
- `match_X_rsN` = `dec_valid` & `dec_use_rsN` & tag X writes `dec_rsN`.
- `rsN_ex` = match_EX_rsN & !EX.load.
- `rsN_mem` = match_MEM_rsN & !MEM.load.
- `load_raw_wb_dec_rsN` = match_WB_rsN & WB.load. This forces the decode mux onto the regfile/WB-bypass path.
- `stall` = !`redirect` & (any match_EX_rsN with EX.load, or any match_MEM_rsN with MEM.load). A load-use stall therefore lasts 2 cycles when the consumer directly follows the load, and 1 cycle with one instruction in between.
- `flush_if` = `flush_dec` = `redirect`. Redirect has priority over stall.
- `we_valid` = WB.valid & WB.we.
- `stall_cnt` += 1 per cycle with `stall`; `flush_cnt` += 1 per cycle with `redirect`. Both saturate at all-ones and never wrap.
- Any operand that reads x0 never flags a hazard or stall.

## Timing
- All hazard, stall, flush and `we_valid` outputs are combinational from the current `dec_*`/`redirect` inputs and the registered tags; zero-cycle latency.
- Tags and counters update on the rising clock edge.
- Reset (async assert, any cycle) clears every tag to invalid and both counters to 0.
  - With tags invalid and `redirect` low: `RAW_hazards` = 0, `RAW_mem_wb_hazards` = 0, `stall` = 0, `we_valid` = 0, flushes = 0.
  - Reset mid-stall drops the stall immediately.
- `redirect` and a load-use condition in the same cycle: flush only. The EX slot becomes a bubble and `stall_cnt` does not increment.
- EX and MEM matches on the same operand: both bits are asserted; the decode encoder gives EX priority.
- Back-to-back redirects: each cycle counts and each cycle flushes.

## Structure
- Shared package/header holds:
  - stage-tag layout {valid, rd[4:0], we, load} and the bubble tag constant;
  - the `RAW_hazards` bit-order constants shared with decode;
  - the REG_X0 = 5'd0 constant.
- One natural sub-module: `stage_tag_match` (tag, rs, use, dec_valid → match, is_load). It is instantiated six times (3 stages × 2 operands).
- Counters stay inline.

## Test plan
- After reset, with dec_valid=1 and rs1=rs2=5: all outputs 0, counters 0.
- ADD x5 followed by dependent ADD rs1=x5: RAW_hazards=4'b1000, stall=0. Next cycle (x5 now in MEM): RAW_hazards=4'b0010.
- LW x7 followed by ADD rs2=x7:
  - stall=1 for 2 cycles, stall_cnt=2;
  - third cycle: RAW_mem_wb_hazards=2'b01, stall=0.
- Load-use pending while redirect=1: stall=0, flush_if=flush_dec=1, flush_cnt=1, EX tag becomes a bubble (next cycle no EX match).
- Producer writes x0, consumer reads x0 (and LUI): no hazard bits, no stall. we_valid follows WB.we only when WB.valid=1.
- Assert rst during the second stall cycle: stall and all hazard bits drop to 0 asynchronously and the counters read 0. With CNT_W=4 and 20 stalls, stall_cnt holds 4'hF.
